ara_sys_arbiter: RTL and testbench

ARA_SYS_ARBITER -- requirements
Module: ara_sys_arbiter

---
 rtl/ara_sys_arbiter.sv | 103 ++++++++++
 tb/tb_ara_sys_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ara_sys_arbiter.sv
// Packet-level arbiter merging the Ara and Ariane request streams onto one master port.
// Ara is preferred, but only for a bounded streak of packets while Ariane is kept waiting.
module ara_sys_arbiter #(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned MaxAraStreak = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ara_valid_i,
  output logic                 ara_ready_o,
  input  logic [DataWidth-1:0] ara_data_i,
  input  logic                 ara_last_i,
  input  logic                 ariane_valid_i,
  output logic                 ariane_ready_o,
  input  logic [DataWidth-1:0] ariane_data_i,
  input  logic                 ariane_last_i,
  output logic                 mst_valid_o,
  input  logic                 mst_ready_i,
  output logic [DataWidth-1:0] mst_data_o,
  output logic                 mst_last_o,
  output logic                 mst_sel_o,
  output logic [3:0]           streak_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOCK_ARIANE = 2'd1,
    LOCK_ARA    = 2'd2
  } state_e;

  localparam logic [3:0] StreakMax = 4'(MaxAraStreak);

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       sel;
  logic       hs;
  logic       pkt_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Source selection: fixed while locked, arbitrated only in IDLE.
  always_comb begin
    sel = 1'b1;
    unique case (state_q)
      LOCK_ARIANE: sel = 1'b0;
      LOCK_ARA:    sel = 1'b1;
      default: begin
        if (ara_valid_i && ariane_valid_i) sel = (streak_q < StreakMax);
        else if (ariane_valid_i)           sel = 1'b0;
        else                               sel = 1'b1;
      end
    endcase
  end

  always_comb begin
    mst_sel_o      = sel;
    mst_valid_o    = sel ? ara_valid_i : ariane_valid_i;
    mst_data_o     = sel ? ara_data_i  : ariane_data_i;
    mst_last_o     = sel ? ara_last_i  : ariane_last_i;
    ara_ready_o    = 1'b0;
    ariane_ready_o = 1'b0;
    // In IDLE with nothing valid no port is offered a ready.
    if (state_q != IDLE || mst_valid_o) begin
      if (sel) ara_ready_o    = mst_ready_i;
      else     ariane_ready_o = mst_ready_i;
    end
  end

  assign hs       = mst_valid_o && mst_ready_i;
  assign pkt_done = hs && mst_last_o;
  assign streak_o = streak_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOCK_ARIANE, LOCK_ARA: if (pkt_done) state_d = IDLE;
      default: begin
        // Lock as soon as a beat is presented so it cannot be withdrawn or switched.
        if (mst_valid_o && !pkt_done) state_d = sel ? LOCK_ARA : LOCK_ARIANE;
        else                          state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (pkt_done) begin
      if (sel && ariane_valid_i)
        streak_d = (streak_q >= StreakMax) ? StreakMax : streak_q + 4'd1;
      else
        streak_d = 4'd0;
    end
  end

endmodule

// File: tb/tb_ara_sys_arbiter.sv
// Randomized and directed bench for ara_sys_arbiter against a packet-level reference model.
module tb_ara_sys_arbiter;

  localparam int DW  = 64;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ara_valid = 1'b0, ara_ready, ara_last = 1'b0;
  logic [DW-1:0] ara_data = '0;
  logic          ariane_valid = 1'b0, ariane_ready, ariane_last = 1'b0;
  logic [DW-1:0] ariane_data = '0;
  logic          mst_valid, mst_ready = 1'b0, mst_last, mst_sel;
  logic [DW-1:0] mst_data;
  logic [3:0]    streak;

  int checks = 0;
  int errors = 0;

  // Reference model: owner of the current packet (-1 none, 0 Ariane, 1 Ara) and streak count.
  int owner  = -1;
  int m_streak = 0;

  ara_sys_arbiter #(.DataWidth(DW), .MaxAraStreak(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ara_valid_i(ara_valid), .ara_ready_o(ara_ready), .ara_data_i(ara_data), .ara_last_i(ara_last),
    .ariane_valid_i(ariane_valid), .ariane_ready_o(ariane_ready), .ariane_data_i(ariane_data),
    .ariane_last_i(ariane_last),
    .mst_valid_o(mst_valid), .mst_ready_i(mst_ready), .mst_data_o(mst_data), .mst_last_o(mst_last),
    .mst_sel_o(mst_sel), .streak_o(streak)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One cycle: drive inputs, check combinational outputs against the model, then advance the model.
  task automatic step(input logic av, input logic [DW-1:0] ad, input logic al,
                      input logic rv, input logic [DW-1:0] rd, input logic rl, input logic mr,
                      output logic sel_seen, output logic [DW-1:0] data_seen,
                      output logic [3:0] streak_after);
    int e_sel;
    logic e_valid, e_last, e_ara_rdy, e_ari_rdy, done;
    logic [DW-1:0] e_data;
    @(negedge clk);
    ara_valid = av; ara_data = ad; ara_last = al;
    ariane_valid = rv; ariane_data = rd; ariane_last = rl;
    mst_ready = mr;
    #1;
    if (owner >= 0)           e_sel = owner;
    else if (av && rv)        e_sel = (m_streak >= MAX) ? 0 : 1;
    else if (rv)              e_sel = 0;
    else                      e_sel = 1;
    e_valid   = (e_sel == 1) ? av : rv;
    e_data    = (e_sel == 1) ? ad : rd;
    e_last    = (e_sel == 1) ? al : rl;
    e_ara_rdy = (e_sel == 1) && mr && (owner >= 0 || e_valid);
    e_ari_rdy = (e_sel == 0) && mr && (owner >= 0 || e_valid);
    check_eq("sel", 64'(mst_sel), 64'(e_sel));
    check_eq("mst_valid", 64'(mst_valid), 64'(e_valid));
    if (e_valid) begin
      check_eq("mst_data", mst_data, e_data);
      check_eq("mst_last", 64'(mst_last), 64'(e_last));
    end
    check_eq("ara_ready", 64'(ara_ready), 64'(e_ara_rdy));
    check_eq("ariane_ready", 64'(ariane_ready), 64'(e_ari_rdy));
    check_eq("streak", 64'(streak), 64'(m_streak));
    sel_seen  = mst_sel;
    data_seen = mst_data;
    done = e_valid && mr && e_last;
    @(posedge clk);
    if (done) begin
      if (e_sel == 1) m_streak = rv ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
      else            m_streak = 0;
      owner = -1;
    end else if (owner < 0 && e_valid) begin
      owner = e_sel;
    end
    #1;
    streak_after = streak;
  endtask

  // Asynchronous reset pulse placed between clock edges, idle outputs checked while held.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    ara_valid = 1'b0; ariane_valid = 1'b0;
    #1;
    check_eq("rst_mst_valid", 64'(mst_valid), 64'd0);
    check_eq("rst_ara_ready", 64'(ara_ready), 64'd0);
    check_eq("rst_ariane_ready", 64'(ariane_ready), 64'd0);
    check_eq("rst_streak", 64'(streak), 64'd0);
    owner = -1; m_streak = 0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic s; logic [DW-1:0] d, d0; logic [3:0] st;
    logic exp_sel[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   exp_str[6]  = '{1, 2, 3, 4, 0, 1};

    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // No valids: idle outputs.
    step(0, 0, 0, 0, 0, 0, 1, s, d, st);
    check_eq("idle_sel", 64'(s), 64'd1);

    // Both valid, single-beat packets: bounded Ara streak then one Ariane grant.
    for (int i = 0; i < 6; i++) begin
      step(1, rnd64(), 1, 1, rnd64(), 1, 1, s, d, st);
      check_eq("streak_order_sel", 64'(s), 64'(exp_sel[i]));
      check_eq("streak_order_cnt", 64'(st), 64'(exp_str[i]));
    end
    pulse_reset();

    // Ara 3-beat packet; Ariane raises valid at beat 2 and must wait for Ara last.
    step(1, 64'hA1, 0, 0, 64'hB1, 1, 1, s, d, st);
    step(1, 64'hA2, 0, 1, 64'hB1, 1, 1, s, d, st);
    check_eq("lock_ara_b2", 64'(s), 64'd1);
    step(1, 64'hA3, 1, 1, 64'hB1, 1, 1, s, d, st);
    check_eq("lock_ara_b3", 64'(s), 64'd1);
    step(0, 64'hA4, 1, 1, 64'hB1, 1, 1, s, d, st);
    check_eq("ariane_after_ara", 64'(s), 64'd0);

    // Ariane held by backpressure while Ara becomes valid: selection and data stay put.
    step(0, 0, 0, 1, 64'hC0FFEE, 1, 0, s, d0, st);
    for (int i = 1; i < 5; i++) begin
      step(i >= 1, rnd64(), 1, 1, 64'hC0FFEE, 1, 0, s, d, st);
      check_eq("bp_sel", 64'(s), 64'd0);
      check_eq("bp_data", d, d0);
    end
    step(1, rnd64(), 1, 1, 64'hC0FFEE, 1, 1, s, d, st);
    check_eq("bp_accept_sel", 64'(s), 64'd0);

    // Only Ara traffic: streak stays zero, a grant every cycle.
    for (int i = 0; i < 10; i++) begin
      step(1, rnd64(), 1, 0, 0, 0, 1, s, d, st);
      check_eq("ara_only_sel", 64'(s), 64'd1);
      check_eq("ara_only_streak", 64'(st), 64'd0);
    end

    // Reset during beat 2 of a 4-beat Ariane packet, then Ara granted at once.
    step(0, 0, 0, 1, 64'h11, 0, 1, s, d, st);
    step(0, 0, 0, 1, 64'h12, 0, 1, s, d, st);
    pulse_reset();
    step(1, 64'h77, 1, 1, 64'h13, 0, 1, s, d, st);
    check_eq("post_reset_ara", 64'(s), 64'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step($urandom_range(0, 9) < 8, rnd64(), $urandom_range(0, 9) < 5,
           $urandom_range(0, 9) < 7, rnd64(), $urandom_range(0, 9) < 5,
           $urandom_range(0, 9) < 7, s, d, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
